// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: word, cache line, and the L2 arbiter state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [255:0] lc3b_cline;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } cache_arb_state;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto the single L2 mem_* port,
// one registered transaction at a time, and steers the L2 response back to the owner.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int FAIR = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_read,
  input  lc3b_word  i_address,
  output logic      i_resp,
  output lc3b_cline i_rdata,
  input  logic      d_read,
  input  logic      d_write,
  input  lc3b_word  d_address,
  input  lc3b_cline d_wdata,
  output logic      d_resp,
  output lc3b_cline d_rdata,
  output logic      mem_read,
  output logic      mem_write,
  output lc3b_word  mem_address,
  output lc3b_cline mem_wdata,
  input  logic      mem_resp,
  input  lc3b_cline mem_rdata
);

  cache_arb_state state_q;
  logic           last_d_q;   // 1: D-cache owned the most recent grant
  logic           mem_read_q, mem_write_q;
  lc3b_word       mem_address_q;
  lc3b_cline      mem_wdata_q;

  logic i_pend, d_pend, gnt_i, gnt_d;

  always_comb begin
    i_pend = i_read;
    d_pend = d_read | d_write;
    gnt_i  = 1'b0;
    gnt_d  = 1'b0;
    if (i_pend && d_pend) begin
      if (FAIR != 0) begin
        gnt_i = last_d_q;
        gnt_d = ~last_d_q;
      end else begin
        gnt_d = 1'b1;
      end
    end else begin
      gnt_i = i_pend;
      gnt_d = d_pend;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_d_q      <= 1'b1;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_i) begin
            state_q       <= SERVE_I;
            last_d_q      <= 1'b0;
            mem_address_q <= i_address;
            mem_read_q    <= 1'b1;
            mem_write_q   <= 1'b0;
          end else if (gnt_d) begin
            state_q       <= SERVE_D;
            last_d_q      <= 1'b1;
            mem_address_q <= d_address;
            // read+write together is treated as a writeback
            mem_read_q    <= ~d_write;
            mem_write_q   <= d_write;
            if (d_write) mem_wdata_q <= d_wdata;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state_q     <= DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_resp      = (state_q == SERVE_I) && mem_resp;
  assign d_resp      = (state_q == SERVE_D) && mem_resp;
  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Upstream initiator for the L2 cache's line-request port: arbitrates between the L1 instruction cache (read-only) and the L1 data cache (read/write), and drives one registered, line-wide (`lc3b_cline`, 256-bit) transaction at a time into the L2 `mem_*` slave interface. Responses from L2 are steered back to the requester that owns the grant. It sits between the split L1 caches and `l2cache`, in the memory hierarchy below the pipeline.

## Interface
- `FAIR`, default 1: 1 = round-robin on simultaneous requests; 0 = data cache always wins ties.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `i_read`  in  1  I-cache line read request, level-held until `i_resp`.
- `i_address`  in  16 (`lc3b_word`)  I-cache line address.
- `i_resp`  out  1  one-cycle completion pulse to I-cache.
- `i_rdata`  out  256 (`lc3b_cline`)  read line to I-cache, valid when `i_resp`=1.
- `d_read`, `d_write`  in  1 each  D-cache line requests, level-held until `d_resp`.
- `d_address`  in  16  D-cache line address.
- `d_wdata`  in  256  D-cache writeback line.
- `d_resp`  out  1  one-cycle completion pulse to D-cache.
- `d_rdata`  out  256  read line to D-cache, valid when `d_resp`=1.
- `mem_read`, `mem_write`  out  1 each  request strobes to L2, held until `mem_resp`.
- `mem_address`  out  16  registered address to L2.
- `mem_wdata`  out  256  registered write line to L2.
- `mem_resp`  in  1  L2 completion pulse.
- `mem_rdata`  in  256  L2 read line, valid with `mem_resp`.

## Operation
- States: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE: if no request, stay. Requests pending: I if `i_read`; D if `d_read|d_write`.
  - Only one pending → grant it.
  - Both pending, `FAIR`=1 → grant the one not equal to `last_served`; `FAIR`=0 → grant D.
  - On grant, capture address (and `d_wdata` for writes) into output registers, set `mem_read`/`mem_write`, update `last_served`.
- SERVE_I / SERVE_D: outputs held stable; request inputs ignored. On `mem_resp`: pulse owner's `*_resp`, clear `mem_read`/`mem_write`, go DONE.
- DONE: one bubble cycle so a requester dropping its level-held request after `*_resp` is never re-granted; → IDLE unconditionally.
- `d_read` and `d_write` both high: treated as write (`mem_write`=1, `mem_read`=0).
- `i_rdata`/`d_rdata` are combinational copies of `mem_rdata`; both carry it at all times, meaningful only with the matching `*_resp`.
- `mem_resp` outside SERVE_* is ignored.
- `mem_wdata` holds last captured value when idle; zero after reset.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `last_served`=D, `mem_read`=`mem_write`=0, `mem_address`=0, `mem_wdata`=0, `i_resp`=`d_resp`=0. Reset mid-transaction abandons it without any `*_resp`; L2 is reset concurrently.
- Request high in IDLE at cycle N → `mem_read`/`mem_write` high at cycle N+1.
- `mem_resp` at cycle M → `*_resp` high in cycle M (combinational from `mem_resp` and state), `mem_*` strobes low from M+1, IDLE at M+2, earliest next grant strobe at M+3.
- Minimum arbiter overhead: 2 cycles per transaction beyond L2 latency.
- Request raised while another is served waits; no request is dropped.

## Structure
- `lc3b_types` provides `lc3b_word`, `lc3b_cline`; add `cache_arb_state` enum (IDLE, SERVE_I, SERVE_D, DONE) there.
- Single module; grant selection fits in one combinational block. No sub-module required.

## Test plan
- I-only read, `i_address`=0x1240, L2 returns line 0xA5…A5 after 5 cycles → `mem_read`=1 with `mem_address`=0x1240 one cycle after request; `i_resp` pulses once with `i_rdata`=0xA5…A5; `d_resp` stays 0.
- D write, `d_address`=0x3FE0, `d_wdata`=0x0123…CDEF → `mem_write`=1, `mem_wdata` matches, `mem_read`=0; single `d_resp`.
- Simultaneous `i_read` and `d_read` from reset, `FAIR`=1, both held → I served first, then D; with `FAIR`=0 → D first.
- Both requesters continuously re-requesting for 6 transactions, `FAIR`=1 → strict I,D,I,D,I,D alternation; no duplicate grant from DONE bubble.
- `rst_n`=0 two cycles after D grant with `mem_resp` never asserted → next cycle all outputs 0, state IDLE; subsequent `i_read` granted normally.
- `d_read`=`d_write`=1 at address 0x0100 → `mem_write`=1 only; spurious `mem_resp` in IDLE → no `*_resp`.
